// File: rtl/tilt_conditioner_if.sv
// Sample/frame/calibration bus between the accelerometer front end and tilt_conditioner.
// The master modport drives stimulus; the slave modport is the conditioner itself.
interface tilt_conditioner_if #(
  parameter int unsigned SAMPLE_W = 12
) ();
  logic                       frame;
  logic                       sample_valid;
  logic                       sample_axis;
  logic signed [SAMPLE_W-1:0] sample_data;
  logic                       cal_req;
  logic                       cal_busy;
  logic [3:0]                 tilt_amount_x;
  logic [3:0]                 tilt_amount_y;
  logic                       tilt_direction_x;
  logic                       tilt_direction_y;

  modport master (
    output frame, sample_valid, sample_axis, sample_data, cal_req,
    input  cal_busy, tilt_amount_x, tilt_amount_y, tilt_direction_x, tilt_direction_y
  );

  modport slave (
    input  frame, sample_valid, sample_axis, sample_data, cal_req,
    output cal_busy, tilt_amount_x, tilt_amount_y, tilt_direction_x, tilt_direction_y
  );
endinterface

// File: rtl/tilt_conditioner.sv
// Per-axis moving-average tilt filter with deadzone, quantiser and frame-latched outputs.
// Define TILT_CALIB_EN to build the zero-offset calibration state machine.
module tilt_conditioner #(
  parameter int unsigned SAMPLE_W  = 12,
  parameter int unsigned AVG_LOG2  = 3,
  parameter int unsigned DEADZONE  = 16,
  parameter int unsigned MAG_SHIFT = 5
) (
  input logic               clk,
  input logic               rst,
  tilt_conditioner_if.slave bus
);
  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = SAMPLE_W + AVG_LOG2;
  localparam int unsigned VW    = SAMPLE_W + 1;

  logic signed [SAMPLE_W-1:0] ring_q [2][Depth];
  logic        [AVG_LOG2-1:0] ptr_q  [2];
  logic signed [SumW-1:0]     sum_q  [2];
  logic signed [SAMPLE_W-1:0] avg    [2];
  logic signed [SAMPLE_W-1:0] offset [2];
  logic signed [VW-1:0]       corr   [2];
  logic        [VW-1:0]       abs_v  [2];
  logic        [VW-1:0]       excess;
  logic        [3:0]          amt_d  [2];
  logic        [3:0]          amt_q  [2];
  logic                       dir_d  [2];
  logic                       dir_q  [2];
  logic                       in_run;
  logic                       ax;

  assign ax = bus.sample_axis;

  // Ring buffer and running sum: the new sample displaces the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 2; a++) begin
        sum_q[a] <= '0;
        ptr_q[a] <= '0;
        for (int i = 0; i < Depth; i++) ring_q[a][i] <= '0;
      end
    end else if (bus.sample_valid) begin
      sum_q[ax]             <= sum_q[ax] - SumW'(ring_q[ax][ptr_q[ax]]) + SumW'(bus.sample_data);
      ring_q[ax][ptr_q[ax]] <= bus.sample_data;
      ptr_q[ax]             <= ptr_q[ax] + 1'b1;
    end
  end

  always_comb begin
    excess = '0;
    for (int a = 0; a < 2; a++) begin
      avg[a]   = SAMPLE_W'(sum_q[a] >>> AVG_LOG2);
      corr[a]  = VW'(avg[a]) - VW'(offset[a]);
      abs_v[a] = corr[a][SAMPLE_W] ? VW'(-corr[a]) : VW'(corr[a]);
      amt_d[a] = '0;
      if (abs_v[a] > VW'(DEADZONE)) begin
        excess   = (abs_v[a] - VW'(DEADZONE)) >> MAG_SHIFT;
        amt_d[a] = (excess > VW'(15)) ? 4'd15 : excess[3:0];
      end
      dir_d[a] = ~corr[a][SAMPLE_W] && (amt_d[a] != '0);
    end
  end

  // Latched from sum_q, so a sample arriving with frame is not yet included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < 2; a++) begin
        amt_q[a] <= '0;
        dir_q[a] <= 1'b0;
      end
    end else if (bus.frame && in_run) begin
      for (int a = 0; a < 2; a++) begin
        amt_q[a] <= amt_d[a];
        dir_q[a] <= dir_d[a];
      end
    end
  end

  assign bus.tilt_amount_x    = amt_q[0];
  assign bus.tilt_amount_y    = amt_q[1];
  assign bus.tilt_direction_x = dir_q[0];
  assign bus.tilt_direction_y = dir_q[1];

`ifdef TILT_CALIB_EN
  typedef enum logic {StRun, StCal} state_e;

  localparam logic [AVG_LOG2:0] Full = Depth[AVG_LOG2:0];

  state_e                     state_q, state_d;
  logic        [AVG_LOG2:0]   cnt_q    [2];
  logic signed [SAMPLE_W-1:0] offset_q [2];
  logic                       cal_done;

  assign cal_done = (cnt_q[0] == Full) && (cnt_q[1] == Full);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (bus.cal_req) state_d = StCal;
      StCal:   if (cal_done) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Offsets capture avg one cycle after the last counted sample lands in the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      for (int a = 0; a < 2; a++) begin
        cnt_q[a]    <= '0;
        offset_q[a] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == StRun) begin
        if (bus.cal_req) begin
          cnt_q[0] <= '0;
          cnt_q[1] <= '0;
        end
      end else begin
        if (cal_done) begin
          offset_q[0] <= avg[0];
          offset_q[1] <= avg[1];
        end
        if (bus.sample_valid && (cnt_q[ax] != Full)) cnt_q[ax] <= cnt_q[ax] + 1'b1;
      end
    end
  end

  assign offset       = offset_q;
  assign in_run       = (state_q == StRun);
  assign bus.cal_busy = (state_q == StCal);
`else
  logic unused_cal_req;

  assign unused_cal_req = bus.cal_req;
  assign in_run         = 1'b1;
  assign bus.cal_busy   = 1'b0;

  always_comb begin
    for (int a = 0; a < 2; a++) offset[a] = '0;
  end
`endif

endmodule

// File: tb/tb_tilt_conditioner.sv
// Scoreboard bench for tilt_conditioner: directed scenarios plus random traffic against
// a queue-based averaging model; follows TILT_CALIB_EN the same way the design does.
module tb_tilt_conditioner;
  localparam int SW = 12;
`ifdef TILT_CALIB_EN
  localparam bit CalEn = 1'b1;
`else
  localparam bit CalEn = 1'b0;
`endif

  typedef struct {
    int ax;
    int dx;
    int ay;
    int dy;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tilt_conditioner_if #(.SAMPLE_W(SW)) bus ();

  tilt_conditioner #(
    .SAMPLE_W (SW),
    .AVG_LOG2 (3),
    .DEADZONE (16),
    .MAG_SHIFT(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  // Reference model state
  int   hist_x[$];
  int   hist_y[$];
  int   off[2];
  int   cnt[2];
  bit   m_cal;
  exp_t last;
  bit   started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input int expv);
    total++;
    if (act !== 32'(expv)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int m_avg(input int a);
    int s = 0;
    if (a == 0) foreach (hist_x[i]) s += hist_x[i];
    else foreach (hist_y[i]) s += hist_y[i];
    // floor(s / 8)
    if (s < 0 && (s % 8) != 0) return s / 8 - 1;
    return s / 8;
  endfunction

  function automatic void model_axis(input int a, output int amt, output int dir);
    int v, m;
    v = m_avg(a) - off[a];
    m = (v < 0) ? -v : v;
    if (m <= 16) amt = 0;
    else begin
      amt = (m - 16) / 32;
      if (amt > 15) amt = 15;
    end
    dir = (v > 0 && amt != 0) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    hist_x.delete();
    hist_y.delete();
    for (int i = 0; i < 8; i++) begin
      hist_x.push_back(0);
      hist_y.push_back(0);
    end
    off   = '{0, 0};
    cnt   = '{0, 0};
    m_cal = 1'b0;
    last  = '{0, 0, 0, 0};
  endfunction

  // One clock of stimulus, entered and left on a falling edge.
  task automatic step(input bit f, input bit v, input bit a, input int d, input bit cr,
                      input bit r);
    bit cal_now;
    bus.frame        = f;
    bus.sample_valid = v;
    bus.sample_axis  = a;
    bus.sample_data  = SW'(d);
    bus.cal_req      = cr;
    rst              = r;
    if (r) begin
      model_reset();
      started = 1'b1;
    end else begin
      cal_now = m_cal;
      if (f) begin
        if (!cal_now) begin
          model_axis(0, last.ax, last.dx);
          model_axis(1, last.ay, last.dy);
        end
        exp_q.push_back(last);
      end
      if (cal_now && cnt[0] >= 8 && cnt[1] >= 8) begin
        off[0] = m_avg(0);
        off[1] = m_avg(1);
        m_cal  = 1'b0;
      end else if (!cal_now && cr && CalEn) begin
        m_cal = 1'b1;
        cnt   = '{0, 0};
      end
      if (v) begin
        if (a == 1'b0) begin
          hist_x.push_back(d);
          void'(hist_x.pop_front());
        end else begin
          hist_y.push_back(d);
          void'(hist_y.pop_front());
        end
        if (cal_now && cnt[a] < 8) cnt[a]++;
      end
    end
    @(negedge clk);
    if (started) check("cal_busy", 32'(bus.cal_busy), int'(m_cal));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic fill(input bit a, input int d, input int n);
    repeat (n) step(1'b0, 1'b1, a, d, 1'b0, 1'b0);
  endtask

  task automatic frame_pulse();
    step(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_amt_x"}, 32'(bus.tilt_amount_x), 0);
    check({tag, "_dir_x"}, 32'(bus.tilt_direction_x), 0);
    check({tag, "_amt_y"}, 32'(bus.tilt_amount_y), 0);
    check({tag, "_dir_y"}, 32'(bus.tilt_direction_y), 0);
    check({tag, "_busy"}, 32'(bus.cal_busy), 0);
  endtask

  // Monitor: every accepted frame pulse must be matched by a scoreboard entry.
  initial begin
    logic fs, rs;
    exp_t e;
    forever begin
      @(posedge clk);
      fs = bus.frame;
      rs = rst;
      @(negedge clk);
      if (fs === 1'b1 && rs === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL frame_unexpected: got frame with no expectation expected none");
        end else begin
          e = exp_q.pop_front();
          check("tilt_amount_x", 32'(bus.tilt_amount_x), e.ax);
          check("tilt_direction_x", 32'(bus.tilt_direction_x), e.dx);
          check("tilt_amount_y", 32'(bus.tilt_amount_y), e.ay);
          check("tilt_direction_y", 32'(bus.tilt_direction_y), e.dy);
        end
      end
    end
  end

  initial begin
    int d;
    bus.frame        = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_axis  = 1'b0;
    bus.sample_data  = '0;
    bus.cal_req      = 1'b0;
    rst              = 1'b1;
    @(negedge clk);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check_all_zero("reset");

    // Positive X tilt
    fill(1'b0, 200, 8);
    frame_pulse();
    check("x200_amt", 32'(bus.tilt_amount_x), 5);
    check("x200_dir", 32'(bus.tilt_direction_x), 1);

    // Saturating negative Y tilt
    fill(1'b1, -2047, 8);
    frame_pulse();
    check("ymin_amt", 32'(bus.tilt_amount_y), 15);
    check("ymin_dir", 32'(bus.tilt_direction_y), 0);

    // Deadzone edge and first step above it
    fill(1'b0, 16, 8);
    frame_pulse();
    check("dz16_amt", 32'(bus.tilt_amount_x), 0);
    fill(1'b0, 49, 8);
    frame_pulse();
    check("x49_amt", 32'(bus.tilt_amount_x), 1);

    // Calibration at +100 on both axes
    fill(1'b0, 100, 8);
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 100, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 100, 1'b0, 1'b0);
    end
    idle(2);
    frame_pulse();
    check("cal_amt_x", 32'(bus.tilt_amount_x), CalEn ? 0 : 2);
    fill(1'b0, 300, 8);
    frame_pulse();
    check("cal300_amt_x", 32'(bus.tilt_amount_x), CalEn ? 5 : 8);
    check("cal300_dir_x", 32'(bus.tilt_direction_x), 1);

    // Frame coinciding with a sample latches the pre-sample average
    fill(1'b0, 200, 8);
    step(1'b1, 1'b1, 1'b0, 1000, 1'b0, 1'b0);
    idle(1);
    frame_pulse();

    // Reset in the middle of calibration
    step(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    fill(1'b0, 50, 3);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    check_all_zero("midcal_rst");
    fill(1'b0, 200, 8);
    frame_pulse();
    check("post_rst_amt_x", 32'(bus.tilt_amount_x), 5);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      d = int'($urandom_range(4095)) - 2048;
      step(($urandom_range(9) == 0), ($urandom_range(3) != 0), 1'($urandom_range(1)), d,
           ($urandom_range(59) == 0), ($urandom_range(199) == 0));
    end
    idle(20);
    frame_pulse();
    idle(2);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tilt_conditioner.md
TILT_CONDITIONER -- requirements
Module: tilt_conditioner

Interface
REQ-001 Parameter SAMPLE_W, default 12: width of signed raw accelerometer sample.
REQ-002 Parameter AVG_LOG2, default 3: log2 of moving-average window per axis (8 samples).
REQ-003 Parameter DEADZONE, default 16: magnitude below which the filtered tilt reads zero.
REQ-004 Parameter MAG_SHIFT, default 5: right shift applied after deadzone subtraction.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 frame  input  1  one-cycle pulse at start of each video frame.
REQ-008 sample_valid  input  1  raw sample present this cycle.
REQ-009 sample_axis  input  1  0 = X sample, 1 = Y sample.
REQ-010 sample_data  input  SAMPLE_W  signed two's-complement raw sample.
REQ-011 cal_req  input  1  one-cycle pulse requesting zero-offset calibration.
REQ-012 cal_busy  output  1  high while calibration is in progress.
REQ-013 tilt_amount_x / tilt_amount_y  output  4  quantised tilt magnitude per axis.
REQ-014 tilt_direction_x / tilt_direction_y  output  1  1 = positive filtered tilt, 0 = zero or negative.

Function
REQ-015 Each axis SHALL keep a 2^AVG_LOG2-entry ring buffer, a write pointer, and a running sum of width SAMPLE_W+AVG_LOG2; each accepted sample replaces the oldest entry: sum <= sum - oldest + new, pointer wraps from 2^AVG_LOG2-1 to 0.
REQ-016 avg = sum >>> AVG_LOG2 (arithmetic); avg SHALL be visible one cycle after the sample_valid cycle.
REQ-017 Corrected value v = avg - offset, computed at SAMPLE_W+1 bits so no overflow is possible.
REQ-018 mag = (|v| <= DEADZONE) ? 0 : min(15, (|v| - DEADZONE) >> MAG_SHIFT); dir = (v > 0) and mag != 0.
REQ-019 Outputs SHALL update only on the cycle after frame=1 while state is RUN; they hold stable for the whole frame otherwise.
REQ-020 When frame and sample_valid coincide, the frame latch SHALL use the average from before that sample.
REQ-021 State machine: RUN (default) -> CAL on cal_req; CAL -> RUN when both axes have received 2^AVG_LOG2 samples since entry; offset_x/offset_y <= the current avg on that transition cycle.
REQ-022 cal_busy = 1 exactly while in CAL; cal_req during CAL SHALL be ignored (the counters do not restart).
REQ-023 During CAL, the tilt outputs SHALL hold their last values, and frame pulses SHALL be ignored.
REQ-024 Per-axis calibration counters SHALL saturate at 2^AVG_LOG2; samples for an already-full axis still update its ring buffer.

Reset
REQ-025 On rst=1, all ring entries, sums, pointers and offsets SHALL clear to 0; state SHALL become RUN; all tilt outputs and cal_busy SHALL become 0; rst has priority over every other input.
REQ-026 rst asserted mid-CAL SHALL abort calibration; offsets SHALL return to 0.

Configuration
REQ-027 Macro TILT_CALIB_EN: when defined, the CAL state, offsets and cal_busy are implemented as specified.
REQ-028 Without TILT_CALIB_EN: offsets are constant 0, cal_req is ignored, cal_busy is tied 0, and the state remains RUN.

Verification
REQ-029 After reset, feed 8 X samples of +200 and then pulse frame -> tilt_amount_x=5 ((200-16)>>5), tilt_direction_x=1, Y outputs 0/0.
REQ-030 Feed 8 Y samples of -2047 and then pulse frame -> tilt_amount_y=15 (saturated), tilt_direction_y=0.
REQ-031 Feed 8 X samples of +16 and then pulse frame -> tilt_amount_x=0, tilt_direction_x=0 (deadzone boundary); repeat with +49 -> amount 1.
REQ-032 Fill X with 8 samples of +100, pulse cal_req, feed 8 X samples and 8 Y samples of +100 -> cal_busy high until the 16th sample; on the next frame tilt_amount_x=0. Then 8 samples of +300 -> amount 5, dir 1.
REQ-033 Pulse frame and sample_valid on the same cycle, following 7 prior +200 samples and a new +1000 sample -> outputs reflect the pre-sample average; the following frame reflects the new average.
REQ-034 Assert rst during CAL after 3 samples -> cal_busy=0, all outputs 0, offset 0; a subsequent +200 x8 sequence followed by frame -> amount 5.
